// File: rtl/ms_pkg.sv
// Shared types and constants for the mem_slave block.
//   ms_state_e        : controller state encoding
//   CMD_READ/CMD_WRITE: values of m_s_cmd
//   ERR_RDATA_DEFAULT : default read data for out-of-range reads
package ms_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ACK   = 2'd2,
        ST_RDATA = 2'd3
    } ms_state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_slave_if.sv
// Simple request/ack memory bus between a master and mem_slave.
//   m_s_req   : master request (held until accepted)
//   m_s_addr  : byte address
//   m_s_cmd   : 1 = write, 0 = read
//   m_s_wdata : write data
//   s_m_ack   : one-cycle completion strobe from the slave
//   s_m_rdata : read data, valid in the cycle after ack of a read, else 0
interface master_slave_interface;

    logic        m_s_req;
    logic [31:0] m_s_addr;
    logic        m_s_cmd;
    logic [31:0] m_s_wdata;
    logic        s_m_ack;
    logic [31:0] s_m_rdata;

    modport master_interface (
        output m_s_req,
        output m_s_addr,
        output m_s_cmd,
        output m_s_wdata,
        input  s_m_ack,
        input  s_m_rdata
    );

    modport slave_interface (
        input  m_s_req,
        input  m_s_addr,
        input  m_s_cmd,
        input  m_s_wdata,
        output s_m_ack,
        output s_m_rdata
    );

endinterface

// File: rtl/mem_slave_regfile.sv
// Word storage for mem_slave: one write port, one registered read port.
// Every word and the read register clear on reset.
//   clk, resetn : clock and async active-low reset
//   we_i        : write strobe, waddr_i/wdata_i
//   re_i        : read strobe, captures mem[raddr_i] into rdata_o
//   rdata_o     : registered read data
module mem_slave_regfile #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [31:0]              wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_slave.sv
// Memory-mapped slave with programmable wait states and an out-of-range
// access counter.
//   clk, resetn : clock and async active-low reset
//   bus         : request/ack slave port (see master_slave_interface)
//   wait_cfg    : wait cycles before ack, sampled at accept
//   busy        : high whenever the controller is not idle
//   err_cnt     : saturating count of out-of-range accesses
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | waiting for m_s_req; request latched on accept
// ST_WAIT  | down-counting latched wait cycles
// ST_ACK   | s_m_ack high; write commits / read captured at end
// ST_RDATA | s_m_rdata carries the read word for one cycle
module mem_slave
    import ms_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic                           clk,
    input  logic                           resetn,
    master_slave_interface.slave_interface bus,
    input  logic [3:0]                     wait_cfg,
    output logic                           busy,
    output logic [7:0]                     err_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    ms_state_e   state_q, state_d;
    // Only word-address bits 30:2 matter; bit 31 and the byte offset are dropped.
    logic [28:0] addr_q, addr_d;
    logic        cmd_q, cmd_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic          oor;
    logic [AW-1:0] idx;
    logic          rf_we;
    logic          rf_re;
    logic [31:0]   rf_rdata;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{bus.m_s_addr[31], bus.m_s_addr[1:0]};

    assign idx = addr_q[AW-1:0];
    assign oor = (addr_q >> AW) != '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            cmd_q     <= CMD_READ;
            wdata_q   <= '0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cmd_q     <= cmd_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cmd_d     = cmd_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.m_s_req) begin
                    addr_d  = bus.m_s_addr[30:2];
                    cmd_d   = bus.m_s_cmd;
                    wdata_d = bus.m_s_wdata;
                    cnt_d   = wait_cfg;
                    state_d = (wait_cfg != 4'd0) ? ST_WAIT : ST_ACK;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (oor && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                state_d = (cmd_q == CMD_WRITE) ? ST_IDLE : ST_RDATA;
            end
            ST_RDATA: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Out-of-range writes never reach the array; reads are captured regardless
    // and substituted with ERR_RDATA at the output.
    assign rf_we = (state_q == ST_ACK) && (cmd_q == CMD_WRITE) && !oor;
    assign rf_re = (state_q == ST_ACK) && (cmd_q == CMD_READ);

    mem_slave_regfile #(
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .resetn  (resetn),
        .we_i    (rf_we),
        .waddr_i (idx),
        .wdata_i (wdata_q),
        .re_i    (rf_re),
        .raddr_i (idx),
        .rdata_o (rf_rdata)
    );

    assign bus.s_m_ack   = (state_q == ST_ACK);
    assign bus.s_m_rdata = (state_q != ST_RDATA) ? 32'h0 :
                           (oor ? ERR_RDATA : rf_rdata);
    assign busy          = (state_q != ST_IDLE);
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_mem_slave.sv
module tb_mem_slave;
    import ms_pkg::*;

    localparam int DEPTH = 16;
    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

    logic       clk;
    logic       resetn;
    logic [3:0] wait_cfg;
    logic       busy;
    logic [7:0] err_cnt;

    master_slave_interface bus ();

    mem_slave #(.DEPTH(DEPTH), .ERR_RDATA(ERR_VAL)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .wait_cfg (wait_cfg),
        .busy     (busy),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          ack_cyc;
        bit          rd;
        logic [31:0] rdata;
        int          err;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: word-addressed array plus error counter
    logic [31:0] model_mem [DEPTH];
    int          model_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_err = 0;
    endtask

    // Monitor: pop on ack, check read data and error count one cycle later
    bit   mon_pend = 0;
    exp_t mon_exp;

    always @(negedge clk) begin
        if (!resetn) begin
            mon_pend = 0;
        end else begin
            if (mon_pend) begin
                if (mon_exp.rd) chk("rdata", bus.s_m_rdata, mon_exp.rdata);
                else            chk("rdata_zero_after_write", bus.s_m_rdata, 32'h0);
                chk("err_cnt", {24'h0, err_cnt}, mon_exp.err);
                mon_pend = 0;
            end else if (bus.s_m_rdata !== 32'h0) begin
                checks++;
                errors++;
                $display("FAIL rdata_idle: got %h expected 00000000 (t=%0t)", bus.s_m_rdata, $time);
            end
            if (bus.s_m_ack === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack expected none (t=%0t)", $time);
                end else begin
                    mon_exp = sb_q.pop_front();
                    chk("ack_cycle", cyc, mon_exp.ack_cyc);
                    mon_pend = 1;
                end
            end
        end
    end

    // Issue one request; called and returns at a negedge. acc = cycle of accept edge.
    task automatic issue(input bit cmd, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] w, output int acc);
        exp_t        e;
        int          n;
        logic [31:0] word;
        bus.m_s_req   = 1'b1;
        bus.m_s_cmd   = cmd;
        bus.m_s_addr  = addr;
        bus.m_s_wdata = wd;
        wait_cfg      = w;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got busy expected idle (t=%0t)", $time);
            bus.m_s_req = 1'b0;
            acc = -1;
            return;
        end
        word    = (addr & 32'h7FFF_FFFF) >> 2;
        e.rd    = (cmd == CMD_READ);
        e.rdata = 32'h0;
        if (word >= DEPTH) begin
            if (model_err < 255) model_err++;
            if (e.rd) e.rdata = ERR_VAL;
        end else if (!e.rd) begin
            model_mem[word % DEPTH] = wd;
        end else begin
            e.rdata = model_mem[word % DEPTH];
        end
        e.err     = model_err;
        e.ack_cyc = cyc + 1 + int'(w);
        sb_q.push_back(e);
        acc = cyc + 1;
        @(negedge clk);
        // Junk on the inputs while busy must not matter
        bus.m_s_req   = 1'b0;
        bus.m_s_cmd   = 1'($urandom_range(0, 1));
        bus.m_s_addr  = $urandom;
        bus.m_s_wdata = $urandom;
        wait_cfg      = 4'($urandom_range(0, 15));
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || busy || mon_pend) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", {31'h0, n < 300}, 32'h1);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_in_range_addr();
        int idx = $urandom_range(0, DEPTH - 1);
        return ($urandom & 32'h8000_0003) | (32'(idx) << 2);
    endfunction

    initial begin
        int acc, prev, rel, n;
        bit cmd;
        logic [3:0] w;
        logic [31:0] a;

        resetn        = 1'b0;
        bus.m_s_req   = 1'b0;
        bus.m_s_cmd   = 1'b0;
        bus.m_s_addr  = '0;
        bus.m_s_wdata = '0;
        wait_cfg      = '0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("reset_ack", {31'h0, bus.s_m_ack}, 32'h0);
        chk("reset_rdata", bus.s_m_rdata, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_err_cnt", {24'h0, err_cnt}, 32'h0);
        resetn = 1'b1;
        rel = cyc;

        // Zero-wait write then read
        issue(CMD_WRITE, 32'h0000_0008, 32'h1234_5678, 4'd0, acc);
        chk("first_accept_after_reset", acc, rel + 1);
        issue(CMD_READ, 32'h0000_0008, 32'h0, 4'd0, acc);
        drain();

        // Wait states on a read with addr[31] set
        issue(CMD_READ, 32'h8000_0004, 32'h0, 4'd5, acc);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles_w5_read", n, 7);
        drain();

        // Out-of-range write and read
        issue(CMD_WRITE, 32'h0000_0040, 32'hFFFF_FFFF, 4'd0, acc);
        issue(CMD_READ, 32'h0000_0040, 32'h0, 4'd0, acc);
        drain();
        chk("err_cnt_after_oor", {24'h0, err_cnt}, 32'd2);
        issue(CMD_READ, 32'h0000_0000, 32'h0, 4'd0, acc);
        drain();

        // Request dropped during WAIT (issue drops req one cycle after accept)
        issue(CMD_WRITE, 32'h0000_000C, 32'hA5A5_0033, 4'd3, acc);
        issue(CMD_READ, 32'h0000_000C, 32'h0, 4'd0, acc);
        drain();

        // Reset in the middle of a waited write
        issue(CMD_WRITE, 32'h0000_0000, 32'hCAFE_F00D, 4'd4, acc);
        @(negedge clk);
        resetn = 1'b0;
        sb_q.delete();
        model_reset();
        @(negedge clk);
        chk("midreset_busy", {31'h0, busy}, 32'h0);
        chk("midreset_ack", {31'h0, bus.s_m_ack}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        rel = cyc;
        issue(CMD_READ, 32'h0000_0000, 32'h0, 4'd0, acc);
        chk("accept_after_midreset", acc, rel + 1);
        drain();
        chk("err_cnt_after_midreset", {24'h0, err_cnt}, 32'h0);

        // Back-to-back throughput
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            issue(CMD_WRITE, rand_in_range_addr(), $urandom, 4'd2, acc);
            if (prev >= 0) chk("write_throughput", acc - prev, 4);
            prev = acc;
        end
        prev = -1;
        for (int i = 0; i < 3; i++) begin
            issue(CMD_READ, rand_in_range_addr(), 32'h0, 4'd1, acc);
            if (prev >= 0) chk("read_throughput", acc - prev, 4);
            prev = acc;
        end
        drain();

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            cmd = 1'($urandom_range(0, 1));
            w   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            if ($urandom_range(0, 5) == 0) a = $urandom | 32'h0000_0400;
            else                           a = rand_in_range_addr();
            issue(cmd, a, $urandom, w, acc);
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            issue(CMD_READ, 32'h0000_1000, 32'h0, 4'd0, acc);
        end
        drain();
        chk("err_cnt_saturated", {24'h0, err_cnt}, 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_slave.md
MEM_SLAVE -- requirements
Module: mem_slave

Interface
REQ-001 Parameter DEPTH, default 16, meaning number of 32-bit words in the storage array (power of two, 2..256).
REQ-002 Parameter ERR_RDATA, default 32'hDEAD_BEEF, meaning read data returned for an out-of-range address.
REQ-003 The one clock is clk and the reset is resetn; resetn is asynchronous and active-low, with no other clock or reset.
REQ-004 Port clk, input, 1 bit: global clock; all state changes on its rising edge.
REQ-005 Port resetn, input, 1 bit: global asynchronous active-low reset.
REQ-006 Port bus, master_slave_interface.slave_interface: m_s_req, m_s_addr[31:0], m_s_cmd (1=write, 0=read) and m_s_wdata[31:0] are inputs; s_m_ack and s_m_rdata[31:0] are outputs.
REQ-007 Port wait_cfg, input, 4 bits: number of wait cycles to insert before ack, sampled when a request is accepted.
REQ-008 Port busy, output, 1 bit: high in every state except IDLE.
REQ-009 Port err_cnt, output, 8 bits: saturating count of out-of-range accesses.

Function
REQ-010 The FSM SHALL have states IDLE, WAIT, ACK and RDATA, held in a registered state variable.
REQ-011 In IDLE with m_s_req=1, the block SHALL latch addr, cmd, wdata and wait_cfg, then go to WAIT if wait_cfg is nonzero, else to ACK.
REQ-012 WAIT SHALL decrement the latched count each cycle and go to ACK on the cycle the count reaches 1.
REQ-013 s_m_ack SHALL be high for exactly one cycle, in state ACK, so ack occurs W+1 cycles after the accept edge (W = wait_cfg).
REQ-014 A write SHALL update mem[index] on the clock edge ending the ACK cycle, then go to IDLE.
REQ-015 A read SHALL go from ACK to RDATA; s_m_rdata SHALL carry mem[index] registered during RDATA only, and be 0 in every other state.
REQ-016 RDATA SHALL last one cycle and then go to IDLE.
REQ-017 index SHALL be m_s_addr[1+log2(DEPTH):2]; addr[31] and addr[1:0] SHALL be ignored.
REQ-018 An access is out-of-range if any of addr[30:2+log2(DEPTH)] is nonzero.
REQ-019 Out-of-range writes SHALL be discarded, out-of-range reads SHALL return ERR_RDATA, and both SHALL still ack.
REQ-020 err_cnt SHALL increment in the ACK cycle of each out-of-range access and saturate at 255.
REQ-021 If m_s_req drops during WAIT, the latched transaction SHALL still complete with ack.
REQ-022 Inputs outside IDLE SHALL be ignored; a request held after ack SHALL be accepted as a new transaction on the next IDLE cycle.
REQ-023 Back-to-back throughput SHALL be one transaction per W+2 cycles for writes and W+3 cycles for reads.

Reset
REQ-024 On resetn=0, asynchronously: state=IDLE, s_m_ack=0, s_m_rdata=0, busy=0, err_cnt=0, latched registers=0, all mem words=0.
REQ-025 A reset in the middle of a transaction SHALL abort it with no memory update and no ack after release.
REQ-026 The first request SHALL be accepted on the first rising edge after resetn deasserts.

Structure
REQ-027 Shared package ms_pkg SHALL hold the state enum type, constants CMD_READ=1'b0 and CMD_WRITE=1'b1, and the default ERR_RDATA.
REQ-028 The storage array with reset SHALL be one sub-module, mem_slave_regfile (one write port, one registered read port); the FSM, counter and decode SHALL stay in mem_slave.

Verification
REQ-029 Zero-wait write then read: wait_cfg=0, write addr 0x0000_0008 data 0x1234_5678 -> ack one cycle after accept; read same address -> ack next cycle, rdata 0x1234_5678 the cycle after ack, then 0.
REQ-030 Wait states: wait_cfg=5, read addr 0x8000_0004 -> busy for 7 cycles, ack exactly 6 cycles after accept, rdata 0 (reset value).
REQ-031 Out-of-range: DEPTH=16, write addr 0x0000_0040 data 0xFFFF_FFFF, then read it -> both ack, read returns 0xDEAD_BEEF, err_cnt=2, mem[0] unchanged.
REQ-032 Req dropped during WAIT: wait_cfg=3, write, deassert req after 1 cycle -> ack still issued, data written.
REQ-033 Mid-op reset: wait_cfg=4 write to addr 0x0, assert resetn during WAIT -> no ack, mem[0]=0, busy=0; next request serviced normally.
REQ-034 Saturation: 260 out-of-range reads -> err_cnt holds 255.
